// File: rtl/level_seq_pkg.sv
// ---------------------------------------------------------------------------
// level_seq_pkg
// Shared definitions for the level sequencer:
//   - state_t      : FSM state encodings (PAUSED only reachable when the
//                    LEVEL_SEQ_PAUSE_EN build option is defined)
//   - SCORE_W/TIME_W and their saturation limits
//   - score_sat_add: saturating adder used for diamond scoring
// ---------------------------------------------------------------------------
package level_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        PLAY   = 3'd2,
        DEAD   = 3'd3,
        CLEAR  = 3'd4,
        WIN    = 3'd5,
        PAUSED = 3'd6
    } state_t;

    localparam int SCORE_W = 8;
    localparam int TIME_W  = 10;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;
    localparam logic [TIME_W-1:0]  TIME_MAX  = 10'd999;

    // Adds inc to base and clamps at SCORE_MAX instead of wrapping.
    function automatic logic [SCORE_W-1:0] score_sat_add(
        input logic [SCORE_W-1:0] base,
        input logic [SCORE_W-1:0] inc
    );
        logic [SCORE_W:0] sum;
        sum = {1'b0, base} + {1'b0, inc};
        return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/seq_frame_timer.sv
// ---------------------------------------------------------------------------
// seq_frame_timer
// Tick-driven counter with synchronous clear, count enable and a
// programmable terminal value. hit is a combinational one-cycle pulse on the
// tick that brings the count to terminal; the count wraps to 0 on that tick.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : synchronous clear (wins over counting)
//   enable    : count qualifier
//   tick      : count event (one-cycle pulse)
//   terminal  : number of qualified ticks per hit
//   hit       : terminal pulse
// ---------------------------------------------------------------------------
module seq_frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic         tick,
    input  logic [W-1:0] terminal,
    output logic         hit
);

    logic [W-1:0] count_q;

    assign hit = enable && tick && (count_q == terminal - W'(1));

    // Counter register: clear has priority, then wrap on hit, else increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && tick) begin
            count_q <= hit ? '0 : count_q + W'(1);
        end
    end

endmodule

// File: rtl/level_sequencer.sv
// ---------------------------------------------------------------------------
// level_sequencer
// Game-flow controller sequencing the per-level map renderers. Exactly one
// map is enabled (one-hot map_en) and its object state is held in reset
// while the level (re)loads. Door, hazard and diamond inputs from the active
// map drive advance / retry / finish; score and elapsed seconds feed the HUD.
//
// Build option: LEVEL_SEQ_PAUSE_EN adds the pause input and the PAUSED state.
//
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   start            : one-cycle pulse (Enter) - starts a game / leaves WIN
//   frame_tick       : one-cycle pulse per VGA frame
//   p1/p2_at_door    : players inside their doors (levels)
//   p1/p2_hazard     : players touching a lethal river
//   dimond_touch     : per-diamond sticky touched flags
//   pause            : (option) one-cycle pause toggle
//   state            : current FSM state encoding
//   level            : current 0-based level index
//   map_en           : one-hot map enable
//   map_rst          : reset to the active map's object-state logic
//   score            : diamonds collected, saturating at 255
//   time_sec         : elapsed play seconds, saturating at 999
// ---------------------------------------------------------------------------
module level_sequencer
    import level_seq_pkg::*;
#(
    parameter int N_LEVELS       = 3,
    parameter int N_DIAMOND      = 4,
    parameter int DOOR_FRAMES    = 30,
    parameter int HOLD_FRAMES    = 90,
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 frame_tick,
    input  logic                 p1_at_door,
    input  logic                 p2_at_door,
    input  logic                 p1_hazard,
    input  logic                 p2_hazard,
    input  logic [N_DIAMOND-1:0] dimond_touch,
`ifdef LEVEL_SEQ_PAUSE_EN
    input  logic                 pause,
`endif
    output logic [2:0]           state,
    output logic [1:0]           level,
    output logic [N_LEVELS-1:0]  map_en,
    output logic                 map_rst,
    output logic [SCORE_W-1:0]   score,
    output logic [TIME_W-1:0]    time_sec
);

    localparam int DOOR_W = $clog2(DOOR_FRAMES + 1);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam int SEC_W  = $clog2(FRAMES_PER_SEC + 1);
    localparam logic [1:0] LAST_LEVEL = 2'(N_LEVELS - 1);

    state_t               state_q, next_state;
    logic [1:0]           level_q, next_level;
    logic [SCORE_W-1:0]   score_q, next_score;
    logic [SCORE_W-1:0]   score_base_q, next_score_base;
    logic [TIME_W-1:0]    time_q, next_time;
    logic                 load_cnt_q;
    logic [N_DIAMOND-1:0] dimond_prev_q;
    logic [N_DIAMOND-1:0] dimond_rise;
    logic [SCORE_W-1:0]   rise_cnt;
    logic [N_LEVELS-1:0]  next_map_en;
    logic                 next_map_rst;

    logic in_play;
    logic both_at_door;
    logic hazard;
    logic door_keep;
    logic door_clear;
    logic door_hit;
    logic hold_hit;
    logic sec_hit;

    assign in_play      = (state_q == PLAY);
    assign both_at_door = p1_at_door && p2_at_door;
    assign hazard       = p1_hazard || p2_hazard;

    // Door dwell survives a pause; it restarts on any frame without both
    // players at their doors, and is forced to zero outside a level.
`ifdef LEVEL_SEQ_PAUSE_EN
    assign door_keep = in_play || (state_q == PAUSED);
`else
    assign door_keep = in_play;
`endif
    assign door_clear = !door_keep || (in_play && frame_tick && !both_at_door);

    seq_frame_timer #(.W(DOOR_W)) u_door_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (door_clear),
        .enable   (in_play && both_at_door),
        .tick     (frame_tick),
        .terminal (DOOR_W'(DOOR_FRAMES)),
        .hit      (door_hit)
    );

    seq_frame_timer #(.W(HOLD_W)) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (!(state_q == DEAD || state_q == CLEAR)),
        .enable   (state_q == DEAD || state_q == CLEAR),
        .tick     (frame_tick),
        .terminal (HOLD_W'(HOLD_FRAMES)),
        .hit      (hold_hit)
    );

    // The sub-second count is never cleared by the FSM, so a partial second
    // carries across deaths, level changes and new games.
    seq_frame_timer #(.W(SEC_W)) u_sec_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (1'b0),
        .enable   (in_play),
        .tick     (frame_tick),
        .terminal (SEC_W'(FRAMES_PER_SEC)),
        .hit      (sec_hit)
    );

    // Popcount of newly touched diamonds this cycle.
    always_comb begin
        dimond_rise = dimond_touch & ~dimond_prev_q;
        rise_cnt    = '0;
        for (int i = 0; i < N_DIAMOND; i++) begin
            rise_cnt = rise_cnt + SCORE_W'(dimond_rise[i]);
        end
    end

    // Next-state logic. Hazard outranks door completion (and pause) in PLAY.
    always_comb begin
        next_state      = state_q;
        next_level      = level_q;
        next_score      = score_q;
        next_score_base = score_base_q;
        next_time       = time_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    next_state = LOAD;
                    next_level = 2'd0;
                    next_score = '0;
                    next_time  = '0;
                end
            end
            LOAD: begin
                next_score_base = score_q;
                if (load_cnt_q) begin
                    next_state = PLAY;
                end
            end
            PLAY: begin
                if (rise_cnt != '0) begin
                    next_score = score_sat_add(score_q, rise_cnt);
                end
                if (sec_hit && time_q != TIME_MAX) begin
                    next_time = time_q + TIME_W'(1);
                end
                if (hazard) begin
                    next_state = DEAD;
                end else if (door_hit) begin
                    next_state = CLEAR;
`ifdef LEVEL_SEQ_PAUSE_EN
                end else if (pause) begin
                    next_state = PAUSED;
`endif
                end
            end
            DEAD: begin
                if (hold_hit) begin
                    next_score = score_base_q;
                    next_state = LOAD;
                end
            end
            CLEAR: begin
                if (hold_hit) begin
                    if (level_q == LAST_LEVEL) begin
                        next_state = WIN;
                    end else begin
                        next_level = level_q + 2'd1;
                        next_state = LOAD;
                    end
                end
            end
            WIN: begin
                if (start) begin
                    next_state = IDLE;
                end
            end
`ifdef LEVEL_SEQ_PAUSE_EN
            PAUSED: begin
                if (pause) begin
                    next_state = PLAY;
                end
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Map control is decoded from the next state so it lines up with the
    // registered state output.
    always_comb begin
        next_map_rst = (next_state == IDLE) || (next_state == LOAD);
        next_map_en  = '0;
        if (next_state != IDLE) begin
            for (int i = 0; i < N_LEVELS; i++) begin
                next_map_en[i] = (next_level == 2'(i));
            end
        end
    end

    // State and output registers. load_cnt_q stretches LOAD to two cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            level_q       <= 2'd0;
            score_q       <= '0;
            score_base_q  <= '0;
            time_q        <= '0;
            load_cnt_q    <= 1'b0;
            dimond_prev_q <= '0;
            map_en        <= '0;
            map_rst       <= 1'b1;
        end else begin
            state_q       <= next_state;
            level_q       <= next_level;
            score_q       <= next_score;
            score_base_q  <= next_score_base;
            time_q        <= next_time;
            load_cnt_q    <= (state_q == LOAD) ? ~load_cnt_q : 1'b0;
            dimond_prev_q <= dimond_touch;
            map_en        <= next_map_en;
            map_rst       <= next_map_rst;
        end
    end

    assign state    = state_q;
    assign level    = level_q;
    assign score    = score_q;
    assign time_sec = time_q;

endmodule

// File: tb/tb_level_sequencer.sv
// ---------------------------------------------------------------------------
// tb_level_sequencer
// Directed bench for level_sequencer: one task per scenario, each with its
// own expected values worked out by hand from the game rules.
// ---------------------------------------------------------------------------
module tb_level_sequencer;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_PLAY   = 3'd2;
    localparam logic [2:0] S_DEAD   = 3'd3;
    localparam logic [2:0] S_CLEAR  = 3'd4;
    localparam logic [2:0] S_WIN    = 3'd5;
    localparam logic [2:0] S_PAUSED = 3'd6;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       frame_tick;
    logic       p1_at_door;
    logic       p2_at_door;
    logic       p1_hazard;
    logic       p2_hazard;
    logic [3:0] dimond_touch;
`ifdef LEVEL_SEQ_PAUSE_EN
    logic       pause;
`endif
    logic [2:0] state;
    logic [1:0] level;
    logic [2:0] map_en;
    logic       map_rst;
    logic [7:0] score;
    logic [9:0] time_sec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    level_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .frame_tick   (frame_tick),
        .p1_at_door   (p1_at_door),
        .p2_at_door   (p2_at_door),
        .p1_hazard    (p1_hazard),
        .p2_hazard    (p2_hazard),
        .dimond_touch (dimond_touch),
`ifdef LEVEL_SEQ_PAUSE_EN
        .pause        (pause),
`endif
        .state        (state),
        .level        (level),
        .map_en       (map_en),
        .map_rst      (map_rst),
        .score        (score),
        .time_sec     (time_sec)
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // n frames, each a one-cycle frame_tick pulse followed by an idle cycle.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cycle();
            frame_tick = 1'b0;
            cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; frame_tick = 1'b0;
        p1_at_door = 1'b0; p2_at_door = 1'b0; p1_hazard = 1'b0; p2_hazard = 1'b0;
        dimond_touch = 4'b0000;
`ifdef LEVEL_SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        repeat (3) cycle();
        checks++; if (state !== S_IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d want %0d", state, S_IDLE); end
        checks++; if (level !== 2'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d want 0", level); end
        checks++; if (map_en !== 3'b000) begin errors++; $display("[TB] FAIL reset_map_en: got %b want 000", map_en); end
        checks++; if (map_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset_map_rst: got %b want 1", map_rst); end
        checks++; if (score !== 8'd0) begin errors++; $display("[TB] FAIL reset_score: got %0d want 0", score); end
        checks++; if (time_sec !== 10'd0) begin errors++; $display("[TB] FAIL reset_time: got %0d want 0", time_sec); end
        rst = 1'b0;
        cycle();
        checks++; if (state !== S_IDLE) begin errors++; $display("[TB] FAIL idle_hold: got %0d want %0d", state, S_IDLE); end
    endtask

    task automatic test_load();
        start = 1'b1;
        cycle();
        start = 1'b0;
        checks++; if (state !== S_LOAD) begin errors++; $display("[TB] FAIL load1_state: got %0d want %0d", state, S_LOAD); end
        checks++; if (map_rst !== 1'b1) begin errors++; $display("[TB] FAIL load1_map_rst: got %b want 1", map_rst); end
        checks++; if (map_en !== 3'b001) begin errors++; $display("[TB] FAIL load1_map_en: got %b want 001", map_en); end
        cycle();
        checks++; if (state !== S_LOAD) begin errors++; $display("[TB] FAIL load2_state: got %0d want %0d", state, S_LOAD); end
        checks++; if (map_rst !== 1'b1) begin errors++; $display("[TB] FAIL load2_map_rst: got %b want 1", map_rst); end
        cycle();
        checks++; if (state !== S_PLAY) begin errors++; $display("[TB] FAIL play_state: got %0d want %0d", state, S_PLAY); end
        checks++; if (map_rst !== 1'b0) begin errors++; $display("[TB] FAIL play_map_rst: got %b want 0", map_rst); end
        checks++; if (map_en !== 3'b001 || level !== 2'd0) begin errors++; $display("[TB] FAIL play_map_en: got %b/%0d want 001/0", map_en, level); end
    endtask

    task automatic test_diamonds();
        dimond_touch = 4'b0101;
        cycle();
        checks++; if (score !== 8'd2) begin errors++; $display("[TB] FAIL dia_pair: got %0d want 2", score); end
        repeat (5) cycle();
        checks++; if (score !== 8'd2) begin errors++; $display("[TB] FAIL dia_held: got %0d want 2", score); end
        start = 1'b1;
        cycle();
        start = 1'b0;
        checks++; if (state !== S_PLAY) begin errors++; $display("[TB] FAIL start_ignored: got %0d want %0d", state, S_PLAY); end
    endtask

    task automatic test_door_clear();
        p1_at_door = 1'b1; p2_at_door = 1'b1;
        frames(28);
        p2_at_door = 1'b0;
        frames(1);
        checks++; if (state !== S_PLAY) begin errors++; $display("[TB] FAIL door_abort: got %0d want %0d", state, S_PLAY); end
        p2_at_door = 1'b1;
        frames(29);
        checks++; if (state !== S_PLAY) begin errors++; $display("[TB] FAIL door_29: got %0d want %0d", state, S_PLAY); end
        frames(1);
        checks++; if (state !== S_CLEAR) begin errors++; $display("[TB] FAIL door_30: got %0d want %0d", state, S_CLEAR); end
        p1_at_door = 1'b0; p2_at_door = 1'b0;
        checks++; if (time_sec !== 10'd0) begin errors++; $display("[TB] FAIL time_59: got %0d want 0", time_sec); end
        frames(89);
        checks++; if (state !== S_CLEAR) begin errors++; $display("[TB] FAIL clear_hold89: got %0d want %0d", state, S_CLEAR); end
        frames(1);
        checks++; if (state !== S_LOAD || level !== 2'd1 || map_en !== 3'b010) begin errors++; $display("[TB] FAIL clear_next: got st=%0d lvl=%0d en=%b want st=1 lvl=1 en=010", state, level, map_en); end
        dimond_touch = 4'b0000;
        cycle();
        checks++; if (state !== S_PLAY) begin errors++; $display("[TB] FAIL lvl1_play: got %0d want %0d", state, S_PLAY); end
    endtask

    task automatic test_death_restore();
        dimond_touch = 4'b1010;
        cycle();
        checks++; if (score !== 8'd4) begin errors++; $display("[TB] FAIL lvl1_score: got %0d want 4", score); end
        p1_hazard = 1'b1;
        cycle();
        p1_hazard = 1'b0;
        checks++; if (state !== S_DEAD || map_en !== 3'b010) begin errors++; $display("[TB] FAIL dead_enter: got st=%0d en=%b want st=3 en=010", state, map_en); end
        dimond_touch = 4'b1111;
        cycle();
        checks++; if (score !== 8'd4) begin errors++; $display("[TB] FAIL dead_frozen: got %0d want 4", score); end
        frames(89);
        checks++; if (state !== S_DEAD) begin errors++; $display("[TB] FAIL dead_hold89: got %0d want %0d", state, S_DEAD); end
        frames(1);
        checks++; if (state !== S_LOAD || score !== 8'd2 || level !== 2'd1) begin errors++; $display("[TB] FAIL dead_restore: got st=%0d sc=%0d lvl=%0d want st=1 sc=2 lvl=1", state, score, level); end
        dimond_touch = 4'b0000;
        cycle();
        checks++; if (state !== S_PLAY) begin errors++; $display("[TB] FAIL retry_play: got %0d want %0d", state, S_PLAY); end
    endtask

    task automatic test_hazard_priority();
        p1_at_door = 1'b1; p2_at_door = 1'b1;
        frames(29);
        checks++; if (time_sec !== 10'd1) begin errors++; $display("[TB] FAIL time_88: got %0d want 1", time_sec); end
        p2_hazard = 1'b1; frame_tick = 1'b1;
        cycle();
        checks++; if (state !== S_DEAD) begin errors++; $display("[TB] FAIL hazard_wins: got %0d want %0d", state, S_DEAD); end
        p2_hazard = 1'b0; frame_tick = 1'b0; p1_at_door = 1'b0; p2_at_door = 1'b0;
        cycle();
        frames(90);
        cycle();
        checks++; if (state !== S_PLAY || score !== 8'd2) begin errors++; $display("[TB] FAIL retry2: got st=%0d sc=%0d want st=2 sc=2", state, score); end
    endtask

    task automatic test_clear_level1();
        p1_at_door = 1'b1; p2_at_door = 1'b1;
        frames(30);
        checks++; if (state !== S_CLEAR) begin errors++; $display("[TB] FAIL lvl1_clear: got %0d want %0d", state, S_CLEAR); end
        p1_at_door = 1'b0; p2_at_door = 1'b0;
        frames(90);
        checks++; if (level !== 2'd2 || map_en !== 3'b100) begin errors++; $display("[TB] FAIL lvl2_load: got lvl=%0d en=%b want lvl=2 en=100", level, map_en); end
        cycle();
        checks++; if (state !== S_PLAY) begin errors++; $display("[TB] FAIL lvl2_play: got %0d want %0d", state, S_PLAY); end
    endtask

    task automatic test_score_saturation();
        for (int i = 0; i < 63; i++) begin
            dimond_touch = 4'b1111; cycle();
            dimond_touch = 4'b0000; cycle();
        end
        checks++; if (score !== 8'd254) begin errors++; $display("[TB] FAIL score_254: got %0d want 254", score); end
        dimond_touch = 4'b1111; cycle();
        dimond_touch = 4'b0000; cycle();
        checks++; if (score !== 8'd255) begin errors++; $display("[TB] FAIL score_sat: got %0d want 255", score); end
        dimond_touch = 4'b1111; cycle();
        dimond_touch = 4'b0000; cycle();
        checks++; if (score !== 8'd255) begin errors++; $display("[TB] FAIL score_no_wrap: got %0d want 255", score); end
    endtask

    task automatic test_timer_and_win();
        p1_at_door = 1'b1;
        frames(480);
        checks++; if (time_sec !== 10'd9) begin errors++; $display("[TB] FAIL time_599: got %0d want 9", time_sec); end
        frames(1);
        checks++; if (time_sec !== 10'd10) begin errors++; $display("[TB] FAIL time_600: got %0d want 10", time_sec); end
        p2_at_door = 1'b1;
        frames(30);
        checks++; if (state !== S_CLEAR || time_sec !== 10'd10) begin errors++; $display("[TB] FAIL lvl2_clear: got st=%0d t=%0d want st=4 t=10", state, time_sec); end
        p1_at_door = 1'b0; p2_at_door = 1'b0;
        frames(90);
        checks++; if (state !== S_WIN || map_en !== 3'b100 || level !== 2'd2) begin errors++; $display("[TB] FAIL win: got st=%0d en=%b lvl=%0d want st=5 en=100 lvl=2", state, map_en, level); end
        frames(5);
        checks++; if (time_sec !== 10'd10 || score !== 8'd255) begin errors++; $display("[TB] FAIL win_frozen: got t=%0d sc=%0d want t=10 sc=255", time_sec, score); end
        start = 1'b1;
        cycle();
        start = 1'b0;
        checks++; if (state !== S_IDLE || map_en !== 3'b000 || map_rst !== 1'b1) begin errors++; $display("[TB] FAIL win_to_idle: got st=%0d en=%b rst=%b want st=0 en=000 rst=1", state, map_en, map_rst); end
    endtask

`ifdef LEVEL_SEQ_PAUSE_EN
    task automatic test_pause();
        pause = 1'b1; cycle(); pause = 1'b0;
        checks++; if (state !== S_PAUSED) begin errors++; $display("[TB] FAIL pause_enter: got %0d want %0d", state, S_PAUSED); end
        p1_hazard = 1'b1; cycle(); p1_hazard = 1'b0;
        checks++; if (state !== S_PAUSED) begin errors++; $display("[TB] FAIL pause_hazard: got %0d want %0d", state, S_PAUSED); end
        frames(120);
        checks++; if (time_sec !== 10'd1 || state !== S_PAUSED) begin errors++; $display("[TB] FAIL pause_time: got t=%0d st=%0d want t=1 st=6", time_sec, state); end
        pause = 1'b1; cycle(); pause = 1'b0;
        checks++; if (state !== S_PLAY) begin errors++; $display("[TB] FAIL pause_leave: got %0d want %0d", state, S_PLAY); end
    endtask
`endif

    task automatic test_async_reset();
        start = 1'b1; cycle(); start = 1'b0;
        cycle(); cycle();
        checks++; if (state !== S_PLAY || score !== 8'd0 || time_sec !== 10'd0) begin errors++; $display("[TB] FAIL new_game: got st=%0d sc=%0d t=%0d want st=2 sc=0 t=0", state, score, time_sec); end
        dimond_touch = 4'b0001;
        cycle();
        frames(60);
        checks++; if (score !== 8'd1 || time_sec !== 10'd1) begin errors++; $display("[TB] FAIL pre_rst: got sc=%0d t=%0d want sc=1 t=1", score, time_sec); end
`ifdef LEVEL_SEQ_PAUSE_EN
        test_pause();
`endif
        #2;
        rst = 1'b1;
        #1;
        checks++; if (state !== S_IDLE || level !== 2'd0 || map_en !== 3'b000 || map_rst !== 1'b1 || score !== 8'd0 || time_sec !== 10'd0) begin
            errors++;
            $display("[TB] FAIL async_rst: got st=%0d lvl=%0d en=%b rst=%b sc=%0d t=%0d want 0/0/000/1/0/0", state, level, map_en, map_rst, score, time_sec);
        end
        cycle();
        rst = 1'b0;
        dimond_touch = 4'b0000;
        cycle();
    endtask

    // Safety net so a stuck run still ends with a visible failure.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_load();
        test_diamonds();
        test_door_clear();
        test_death_restore();
        test_hazard_priority();
        test_clear_level1();
        test_score_saturation();
        test_timer_and_win();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
